// File: rtl/spi_arb_defs_pkg.sv
// Shared SPI arbiter definitions: FSM encodings and default bus widths,
// also used by the LUT configuration sequencer.
package spi_arb_defs;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2
    } arb_state_e;

    localparam int ADDR_W_DEF = 13;
    localparam int DATA_W_DEF = 8;

    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first active request at or above the
// pointer, wrapping, reported as one-hot, index and valid.
module rr_priority_pick #(
    parameter int N     = 3,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Rotated priority search; the first hit after the pointer wins.
    always_comb begin
        int v_j;
        o_grant = '0;
        o_idx   = '0;
        o_valid = 1'b0;
        v_j     = 0;
        for (int k = 0; k < N; k++) begin
            v_j = (int'(i_ptr) + k) % N;
            if (!o_valid && i_req[v_j]) begin
                o_valid      = 1'b1;
                o_idx        = IDX_W'(v_j);
                o_grant[v_j] = 1'b1;
            end else begin
                o_valid = o_valid;
            end
        end
    end

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Round-robin arbiter sharing the ADC SPI command master between NUM_REQ
// clients, with locked back-to-back access and a per-transaction timeout.
module spi_cmd_arbiter
    import spi_arb_defs::*;
#(
    parameter int NUM_REQ        = 3,
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ-1:0]        req_we,
    input  logic [NUM_REQ-1:0]        req_lock,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic                      req_err,
    output logic [DATA_W-1:0]         rdata,
    output logic                      cmd_read,
    output logic                      cmd_write,
    output logic [ADDR_W-1:0]         cmd_addr,
    output logic [DATA_W-1:0]         cmd_wdata,
    input  logic                      cmd_read_ack,
    input  logic                      cmd_write_ack,
    input  logic [DATA_W-1:0]         cmd_rdata,
    output logic                      busy,
    output logic [2:0]                grant_id,
    output logic                      timeout_err
);

    localparam int IDX_W = idx_width(NUM_REQ);
    localparam int CNT_W = idx_width(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_e         r_state, w_state_nxt;
    logic [IDX_W-1:0]   r_grant, w_grant_nxt, r_rr, w_rr_nxt;
    logic               r_lock_hold, w_lock_hold_nxt, r_lock_wait, w_lock_wait_nxt;
    logic               r_we, w_we_nxt, r_cmd_read, w_cmd_read_nxt, r_cmd_write, w_cmd_write_nxt;
    logic [ADDR_W-1:0]  r_addr, w_addr_nxt;
    logic [DATA_W-1:0]  r_wdata, w_wdata_nxt, r_rdata, w_rdata_nxt;
    logic [NUM_REQ-1:0] r_ack, w_ack_nxt;
    logic               r_err, w_err_nxt, r_timeout_err, w_timeout_err_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;

    logic [NUM_REQ-1:0] w_pick_grant, w_lock_oh, w_sel_oh;
    logic [IDX_W-1:0]   w_pick_idx, w_sel_idx;
    logic               w_pick_valid, w_use_lock, w_sel_valid, w_sel_we, w_match_ack;
    logic [ADDR_W-1:0]  w_sel_addr;
    logic [DATA_W-1:0]  w_sel_wdata;

    function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] g);
        if (int'(g) >= NUM_REQ - 1) begin
            return '0;
        end else begin
            return g + 1'b1;
        end
    endfunction

    rr_priority_pick #(.N(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .i_req   (req),
        .i_ptr   (r_rr),
        .o_grant (w_pick_grant),
        .o_idx   (w_pick_idx),
        .o_valid (w_pick_valid)
    );

    // Candidate selection: a live lock owner overrides the round-robin pick.
    always_comb begin
        w_lock_oh          = '0;
        w_lock_oh[r_grant] = 1'b1;
        w_use_lock         = r_lock_hold && req[r_grant];
        w_sel_oh           = w_use_lock ? w_lock_oh : w_pick_grant;
        w_sel_idx          = w_use_lock ? r_grant : w_pick_idx;
        w_match_ack        = r_we ? cmd_write_ack : cmd_read_ack;
        w_sel_we           = 1'b0;
        w_sel_addr         = '0;
        w_sel_wdata        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_sel_oh[i]) begin
                w_sel_we    = req_we[i];
                w_sel_addr  = req_addr[i*ADDR_W +: ADDR_W];
                w_sel_wdata = req_wdata[i*DATA_W +: DATA_W];
            end else begin
                w_sel_we = w_sel_we;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_grant_nxt       = r_grant;
        w_rr_nxt          = r_rr;
        w_lock_hold_nxt   = r_lock_hold;
        w_lock_wait_nxt   = r_lock_wait;
        w_we_nxt          = r_we;
        w_cmd_read_nxt    = r_cmd_read;
        w_cmd_write_nxt   = r_cmd_write;
        w_addr_nxt        = r_addr;
        w_wdata_nxt       = r_wdata;
        w_rdata_nxt       = r_rdata;
        w_ack_nxt         = '0;
        w_err_nxt         = 1'b0;
        w_timeout_err_nxt = r_timeout_err;
        w_cnt_nxt         = r_cnt;
        w_sel_valid       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nxt = '0;
                if (w_use_lock) begin
                    w_sel_valid = 1'b1;
                end else if (r_lock_hold && !r_lock_wait) begin
                    // Give an idle lock owner one cycle before releasing it.
                    w_lock_wait_nxt = 1'b1;
                end else begin
                    w_lock_hold_nxt = 1'b0;
                    w_lock_wait_nxt = 1'b0;
                    w_sel_valid     = w_pick_valid;
                end
                if (w_sel_valid) begin
                    w_state_nxt     = S_ISSUE;
                    w_grant_nxt     = w_sel_idx;
                    w_lock_wait_nxt = 1'b0;
                    w_we_nxt        = w_sel_we;
                    w_addr_nxt      = w_sel_addr;
                    w_wdata_nxt     = w_sel_wdata;
                    w_cmd_write_nxt = w_sel_we;
                    w_cmd_read_nxt  = !w_sel_we;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (w_match_ack) begin
                    w_cmd_read_nxt     = 1'b0;
                    w_cmd_write_nxt    = 1'b0;
                    w_ack_nxt[r_grant] = 1'b1;
                    w_rdata_nxt        = r_we ? r_rdata : cmd_rdata;
                    w_rr_nxt           = next_ptr(r_grant);
                    w_lock_hold_nxt    = req_lock[r_grant];
                    w_state_nxt        = S_GAP;
                end else if (r_cnt == CNT_LAST) begin
                    w_cmd_read_nxt     = 1'b0;
                    w_cmd_write_nxt    = 1'b0;
                    w_ack_nxt[r_grant] = 1'b1;
                    w_err_nxt          = 1'b1;
                    w_rdata_nxt        = '0;
                    w_timeout_err_nxt  = 1'b1;
                    w_lock_hold_nxt    = 1'b0;
                    w_rr_nxt           = next_ptr(r_grant);
                    w_state_nxt        = S_GAP;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_GAP: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_grant       <= '0;
            r_rr          <= '0;
            r_lock_hold   <= 1'b0;
            r_lock_wait   <= 1'b0;
            r_we          <= 1'b0;
            r_cmd_read    <= 1'b0;
            r_cmd_write   <= 1'b0;
            r_addr        <= '0;
            r_wdata       <= '0;
            r_rdata       <= '0;
            r_ack         <= '0;
            r_err         <= 1'b0;
            r_timeout_err <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_grant       <= w_grant_nxt;
            r_rr          <= w_rr_nxt;
            r_lock_hold   <= w_lock_hold_nxt;
            r_lock_wait   <= w_lock_wait_nxt;
            r_we          <= w_we_nxt;
            r_cmd_read    <= w_cmd_read_nxt;
            r_cmd_write   <= w_cmd_write_nxt;
            r_addr        <= w_addr_nxt;
            r_wdata       <= w_wdata_nxt;
            r_rdata       <= w_rdata_nxt;
            r_ack         <= w_ack_nxt;
            r_err         <= w_err_nxt;
            r_timeout_err <= w_timeout_err_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    assign req_ack     = r_ack;
    assign req_err     = r_err;
    assign rdata       = r_rdata;
    assign cmd_read    = r_cmd_read;
    assign cmd_write   = r_cmd_write;
    assign cmd_addr    = r_addr;
    assign cmd_wdata   = r_wdata;
    assign busy        = (r_state != S_IDLE);
    assign grant_id    = 3'(r_grant);
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter: reset, round-robin order, reads,
// lock hold/release, timeout and asynchronous reset mid-transaction.
`timescale 1ns/1ps
module tb_spi_cmd_arbiter;

    localparam int N  = 3;
    localparam int AW = 13;
    localparam int DW = 8;
    localparam int TO = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, req_we, req_lock, req_ack;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic            req_err, cmd_read, cmd_write, cmd_read_ack, cmd_write_ack, busy, timeout_err;
    logic [DW-1:0]   rdata, cmd_wdata, cmd_rdata;
    logic [AW-1:0]   cmd_addr;
    logic [2:0]      grant_id;

    int n_checks = 0;
    int n_errors = 0;

    logic [AW-1:0] exp_addr  [3] = '{13'h100, 13'h011, 13'h022};
    logic [DW-1:0] exp_wdata [3] = '{8'hA0, 8'hA1, 8'hA2};

    spi_cmd_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) u_dut (
        .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_ack(req_ack), .req_err(req_err),
        .rdata(rdata), .cmd_read(cmd_read), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata), .cmd_read_ack(cmd_read_ack), .cmd_write_ack(cmd_write_ack),
        .cmd_rdata(cmd_rdata), .busy(busy), .grant_id(grant_id), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic set_req(input int i, input logic we, input logic lock,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_we[i]             = we;
        req_lock[i]           = lock;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // Counts negedges with cmd low until a command appears (bounded).
    task automatic wait_cmd(output int low);
        low = 0;
        while (!(cmd_read || cmd_write) && low < 60) begin
            @(negedge clk);
            low++;
        end
        if (low >= 60) check_eq("cmd_wait", cmd_read | cmd_write, 1'b1);
    endtask

    // Master ack for one cycle; returns at the negedge where req_ack shows.
    task automatic do_ack(input logic is_write, input logic [DW-1:0] d);
        if (is_write) begin
            cmd_write_ack = 1'b1;
        end else begin
            cmd_read_ack = 1'b1;
            cmd_rdata    = d;
        end
        @(negedge clk);
        cmd_write_ack = 1'b0;
        cmd_read_ack  = 1'b0;
        cmd_rdata     = 8'hEE;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int low;
        int n_hi;
        rst = 1'b1; req = '0; req_we = '0; req_lock = '0; req_addr = '0; req_wdata = '0;
        cmd_read_ack = 1'b0; cmd_write_ack = 1'b0; cmd_rdata = 8'h00;
        for (int i = 0; i < 3; i++) set_req(i, 1'b1, 1'b0, exp_addr[i], exp_wdata[i]);
        req = 3'b111;
        repeat (2) @(negedge clk);
        check_eq("rst_cmd", {cmd_read, cmd_write}, 2'b00);
        check_eq("rst_ack", {req_ack, req_err}, 4'h0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_grant", grant_id, 3'd0);
        check_eq("rst_tout", timeout_err, 1'b0);
        check_eq("rst_data", {rdata, cmd_wdata, cmd_addr}, 29'd0);
        rst = 1'b0;

        // Round-robin order 0,1,2,0,1,2 with all three requesting
        for (int t = 0; t < 6; t++) begin
            wait_cmd(low);
            if (t == 0) check_eq("first_latency", low, 1);
            else        check_eq("rr_gap_ge2", low >= 2, 1'b1);
            check_eq("rr_grant", grant_id, t % 3);
            check_eq("rr_write", {cmd_read, cmd_write}, 2'b01);
            check_eq("rr_addr", cmd_addr, exp_addr[t % 3]);
            check_eq("rr_wdata", cmd_wdata, exp_wdata[t % 3]);
            repeat (2) @(negedge clk);
            do_ack(1'b1, 8'h00);
            check_eq("rr_ack", req_ack, 3'b001 << (t % 3));
            check_eq("rr_err", req_err, 1'b0);
            check_eq("rr_cmd_low", cmd_write, 1'b0);
        end
        req = 3'b000;

        // Read by requester 1, stray write ack ignored, data returned
        set_req(1, 1'b0, 1'b0, 13'h01F, 8'h00);
        req = 3'b010;
        wait_cmd(low);
        check_eq("rd_latency", low, 2);
        check_eq("rd_cmd", {cmd_read, cmd_write}, 2'b10);
        check_eq("rd_addr", cmd_addr, 13'h01F);
        check_eq("rd_grant", grant_id, 3'd1);
        repeat (2) @(negedge clk);
        cmd_write_ack = 1'b1;
        @(negedge clk);
        cmd_write_ack = 1'b0;
        check_eq("wrong_ack_ignored", {cmd_read, req_ack}, 4'b1000);
        repeat (8) @(negedge clk);
        do_ack(1'b0, 8'h01);
        check_eq("rd_ack", req_ack, 3'b010);
        check_eq("rd_err", req_err, 1'b0);
        check_eq("rd_data", rdata, 8'h01);
        check_eq("rd_cmd_low", cmd_read, 1'b0);
        req = 3'b000;
        @(negedge clk);
        check_eq("ack_pulse_width", req_ack, 3'b000);

        // Ack in the last permitted cycle still completes without error
        set_req(0, 1'b0, 1'b0, 13'h0F0, 8'h00);
        req = 3'b001;
        wait_cmd(low);
        repeat (TO - 1) @(negedge clk);
        check_eq("last_cycle_cmd", cmd_read, 1'b1);
        do_ack(1'b0, 8'h3C);
        check_eq("last_cycle_ack", {req_ack, req_err}, 4'b0010);
        check_eq("last_cycle_data", rdata, 8'h3C);
        req = 3'b000;

        // Locked read then write by requester 2 while requester 0 waits
        set_req(2, 1'b0, 1'b1, 13'h0A5, 8'h00);
        set_req(0, 1'b1, 1'b0, 13'h0B0, 8'h5B);
        req = 3'b101;
        wait_cmd(low);
        check_eq("lock_grant1", grant_id, 3'd2);
        check_eq("lock_read", {cmd_read, cmd_write}, 2'b10);
        repeat (2) @(negedge clk);
        do_ack(1'b0, 8'h5A);
        check_eq("lock_ack1", {req_ack, rdata}, {3'b100, 8'h5A});
        set_req(2, 1'b1, 1'b1, 13'h0A6, 8'hC3);
        wait_cmd(low);
        check_eq("lock_keep", grant_id, 3'd2);
        check_eq("lock_write", {cmd_write, cmd_wdata}, {1'b1, 8'hC3});
        repeat (2) @(negedge clk);
        do_ack(1'b1, 8'h00);
        check_eq("lock_ack2", req_ack, 3'b100);
        req = 3'b001;
        wait_cmd(low);
        check_eq("lock_release_wait", low, 3);
        check_eq("lock_next_grant", grant_id, 3'd0);
        check_eq("lock_next_addr", cmd_addr, 13'h0B0);
        @(negedge clk);
        do_ack(1'b1, 8'h00);
        check_eq("lock_ack3", req_ack, 3'b001);
        req = 3'b000;
        req_lock = 3'b000;

        // Timeout: master never acks a write from requester 1
        set_req(1, 1'b1, 1'b0, 13'h055, 8'h99);
        req = 3'b010;
        wait_cmd(low);
        n_hi = 1;
        for (int k = 0; k < 40 && cmd_write; k++) begin
            @(negedge clk);
            if (cmd_write) n_hi++;
        end
        check_eq("tout_len", n_hi, TO);
        check_eq("tout_ack", {req_ack, req_err}, 4'b0101);
        check_eq("tout_sticky", timeout_err, 1'b1);
        check_eq("tout_rdata", rdata, 8'h00);
        req = 3'b000;
        for (int k = 0; k < 2; k++) begin
            cmd_write_ack = 1'b1;
            @(negedge clk);
            cmd_write_ack = 1'b0;
            check_eq("late_ack_dropped", {req_ack, busy}, 4'b0000);
        end
        set_req(2, 1'b0, 1'b0, 13'h0C0, 8'h00);
        req = 3'b100;
        wait_cmd(low);
        check_eq("post_tout_grant", {grant_id, cmd_read}, {3'd2, 1'b1});
        repeat (3) @(negedge clk);
        do_ack(1'b0, 8'h77);
        check_eq("post_tout_ack", {req_ack, req_err, rdata}, {3'b100, 1'b0, 8'h77});
        check_eq("tout_still_set", timeout_err, 1'b1);
        req = 3'b000;

        // Async reset in the middle of a read
        set_req(0, 1'b1, 1'b0, 13'h0D0, 8'h11);
        req = 3'b001;
        wait_cmd(low);
        do_ack(1'b1, 8'h00);
        check_eq("pre_rst_ack", req_ack, 3'b001);
        set_req(1, 1'b0, 1'b0, 13'h0E0, 8'h00);
        req = 3'b010;
        wait_cmd(low);
        check_eq("pre_rst_busy", {busy, grant_id}, {1'b1, 3'd1});
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_cmd", {cmd_read, cmd_write, busy}, 3'b000);
        check_eq("arst_ack", req_ack, 3'b000);
        check_eq("arst_regs", {grant_id, timeout_err}, 4'h0);
        req = 3'b101;
        @(negedge clk);
        rst = 1'b0;
        wait_cmd(low);
        check_eq("arst_latency", low, 1);
        check_eq("arst_rr_zero", grant_id, 3'd0);
        check_eq("arst_cmd_addr", {cmd_write, cmd_addr}, {1'b1, 13'h0D0});
        do_ack(1'b1, 8'h00);
        check_eq("arst_ack_after", req_ack, 3'b001);
        req = 3'b000;
        repeat (2) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
